piso_mux_sequencer: RTL
=======================

Name: piso_mux_sequencer

Overview:
- Upstream sequencer for the 8:1 bit-select mux.
- Accepts a byte on a valid/ready handshake and holds it on the mux data bus.
- Steps the 3-bit select through all eight positions at a programmable bit rate, producing a timed serial bitstream.
- Feeds the serial output stage, e.g. LED/pin drivers or the next shift stage in the lab datapath.

Parameters:
- CLK_DIV, 4, clock cycles each bit is held; legal range 1..256.
- MSB_FIRST, 0, 0 = sel counts 0->7 (LSB first); 1 = sel counts 7->0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  upstream has a byte on load_data.
- load_data  in  8  byte to serialise.
- load_ready  out  1  block can accept a byte.
- abort  in  1  synchronous cancel of the current byte.
- data  out  8  latched byte, drives mux data input.
- sel  out  3  mux select.
- serial_out  out  1  data[sel], from the internal mux.
- bit_strobe  out  1  one-cycle pulse on the first cycle of each bit.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, data=8'h00, sel=0 (MSB_FIRST=0) or 7 (MSB_FIRST=1), div counter=0, bit counter=0, bit_strobe=0, busy=0, done=0, load_ready=0 while rst_n low. Takes effect immediately, including mid-byte.
- States: IDLE, SHIFT, DONE. Encoding is a 2-bit enum.
- IDLE:
  - load_ready=1.
  - On a rising edge with load_valid=1: data<=load_data, sel<=start index, div<=0, bitcnt<=0, state<=SHIFT.
  - load_data is ignored when load_valid=0.
- SHIFT:
  - busy=1, load_ready=0.
  - bit_strobe=1 when div==0.
  - div increments each cycle. At div==CLK_DIV-1: div<=0, sel steps by +1 or -1, bitcnt increments.
  - When bitcnt==7 and div==CLK_DIV-1: state<=DONE, sel returns to start index.
  - Total time in SHIFT is exactly 8*CLK_DIV cycles.
- DONE: done=1 for exactly one cycle, load_ready=0, then IDLE. First possible next handshake is the cycle after DONE.
- Latency: handshake at edge E; bit 0 visible on serial_out from E+1; done high in cycle E+8*CLK_DIV+1.
- abort:
  - In SHIFT: state<=IDLE, sel<=start index, div/bitcnt<=0, no done pulse. data keeps its value.
  - In IDLE/DONE: no effect. abort takes priority over the bit step in the same cycle.
- load_valid while busy is ignored. The byte is not captured; upstream must hold it until load_ready.
- CLK_DIV=1: bit_strobe high every SHIFT cycle, sel changes every cycle.
- Widths:
  - div counter is max(1,$clog2(CLK_DIV)) bits.
  - sel wraps mod 8 internally, but is reloaded in DONE, so no wrap is visible.
- serial_out is combinational from registered data/sel, so it is glitch-free relative to clk.

Decomposition:
- Shared package seq_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - BYTE_W=8, SEL_W=3.
  - function start_sel(msb_first).
- Sub-module mux8_1 (data[7:0], sel[2:0] -> y), instantiated once to generate serial_out. This is the same select function as the downstream mux, so bench results cross-check.

Test Plan:
- CLK_DIV=4, MSB_FIRST=0, load 8'hA5 -> serial_out 1,0,1,0,0,1,0,1, each held 4 cycles; sel 0..7; 8 bit_strobe pulses; done in cycle E+33; load_ready high again E+34.
- CLK_DIV=1, MSB_FIRST=1, load 8'h81 -> sel 7,6,...,0 on consecutive cycles; serial_out 1,0,0,0,0,0,0,1; bit_strobe high 8 consecutive cycles.
- Back-to-back load_valid=1 with 8'hFF then 8'h00 -> second byte captured only in the cycle after done. No bit of 8'h00 appears before the 32nd cycle of 8'hFF completes.
- abort asserted on the 3rd bit of 8'h3C -> same cycle-edge return to IDLE, sel=0, busy=0, no done. A fresh load of 8'h0F then serialises correctly.
- rst_n driven low mid-byte asynchronously between edges -> all outputs reach reset values before the next edge. After release, load_ready=1 and the next load works.
- load_valid pulsed while busy with 8'h55 during a 8'hAA transfer -> output remains the 8'hAA pattern and 8'h55 is never captured.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and helpers for the PISO mux sequencer and its bit-select mux.
package seq_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // First select position of a byte: bit 0 for LSB-first, bit 7 for MSB-first.
  function automatic logic [SEL_W-1:0] start_sel(input logic msb_first);
    return msb_first ? SEL_W'(BYTE_W - 1) : '0;
  endfunction

endpackage

// File: rtl/mux8_1.sv
// 8:1 bit-select mux; same select function as the downstream mux it feeds.
module mux8_1
  import seq_pkg::*;
(
  input  logic [BYTE_W-1:0] data,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  assign y = data[sel];

endmodule

// File: rtl/piso_mux_sequencer.sv
// Latches a byte on a valid/ready handshake and steps the mux select through
// all eight bit positions, holding each bit for CLK_DIV cycles.
module piso_mux_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [BYTE_W-1:0] load_data,
  output logic              load_ready,
  input  logic              abort,
  output logic [BYTE_W-1:0] data,
  output logic [SEL_W-1:0]  sel,
  output logic              serial_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_START = start_sel(MSB_FIRST);
  localparam logic [SEL_W-1:0] BIT_LAST  = SEL_W'(BYTE_W - 1);

  state_t              state, state_n;
  logic [BYTE_W-1:0]   data_n;
  logic [SEL_W-1:0]    sel_n, sel_step;
  logic [DIV_W-1:0]    div, div_n;
  logic [SEL_W-1:0]    bitcnt, bitcnt_n;

  assign sel_step = MSB_FIRST ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));

  // Next-state: abort wins over the bit step; the last bit reloads the select.
  always_comb begin
    state_n  = state;
    data_n   = data;
    sel_n    = sel;
    div_n    = div;
    bitcnt_n = bitcnt;
    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          data_n   = load_data;
          sel_n    = SEL_START;
          div_n    = '0;
          bitcnt_n = '0;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          sel_n    = SEL_START;
          div_n    = '0;
          bitcnt_n = '0;
          state_n  = IDLE;
        end else if (div == DIV_LAST) begin
          div_n    = '0;
          bitcnt_n = bitcnt + SEL_W'(1);
          sel_n    = sel_step;
          if (bitcnt == BIT_LAST) begin
            sel_n   = SEL_START;
            state_n = DONE;
          end
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      data       <= '0;
      sel        <= SEL_START;
      div        <= '0;
      bitcnt     <= '0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      state      <= state_n;
      data       <= data_n;
      sel        <= sel_n;
      div        <= div_n;
      bitcnt     <= bitcnt_n;
      bit_strobe <= (state_n == SHIFT) && (div_n == '0);
      busy       <= (state_n == SHIFT);
      done       <= (state_n == DONE);
      load_ready <= (state_n == IDLE);
    end
  end

  mux8_1 u_mux (
    .data (data),
    .sel  (sel),
    .y    (serial_out)
  );

endmodule
